// File: rtl/aes_inv_key_schedule_pkg.sv
// ============================================================================
// Module   : aes_inv_key_schedule_pkg
// Brief    : Shared AES-128 key-schedule constants and helpers (Rcon, word slice)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_inv_key_schedule_pkg;

    localparam int NR_AES128 = 10;

    // Round constant in the top byte; indices outside 1..10 yield zero.
    function automatic logic [31:0] rcon(input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd1:    b = 8'h01;
            4'd2:    b = 8'h02;
            4'd3:    b = 8'h04;
            4'd4:    b = 8'h08;
            4'd5:    b = 8'h10;
            4'd6:    b = 8'h20;
            4'd7:    b = 8'h40;
            4'd8:    b = 8'h80;
            4'd9:    b = 8'h1b;
            4'd10:   b = 8'h36;
            default: b = 8'h00;
        endcase
        return {b, 24'h000000};
    endfunction

    // Word 0 sits in the most significant 32 bits.
    function automatic logic [31:0] key_word(input logic [127:0] key, input logic [1:0] idx);
        return key[{~idx, 5'b00000} +: 32];
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_inv_key_schedule_if.sv
// ============================================================================
// Module   : aes_inv_key_schedule_if
// Brief    : Key-in / round-key-out handshake bundle for the inverse schedule
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aes_inv_key_schedule_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_key;
    logic [3:0]   out_round;
    logic         out_last;

    modport master (
        output in_valid, in_key, out_ready,
        input  in_ready, out_valid, out_key, out_round, out_last
    );

    modport slave (
        input  in_valid, in_key, out_ready,
        output in_ready, out_valid, out_key, out_round, out_last
    );
endinterface

`default_nettype wire

// File: rtl/aes_inv_key_step.sv
// ============================================================================
// Module   : aes_inv_key_step
// Brief    : Combinational undo of one AES-128 forward key-expansion round
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_inv_key_step
    import aes_inv_key_schedule_pkg::*;
(
    input  wire logic [3:0]   rc,
    input  wire logic [127:0] in_key,
    output logic      [127:0] out_key
);

    logic [31:0] w_w4, w_w5, w_w6, w_w7;
    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_rot;
    logic [31:0] w_sub;

    assign w_w4 = key_word(in_key, 2'd0);
    assign w_w5 = key_word(in_key, 2'd1);
    assign w_w6 = key_word(in_key, 2'd2);
    assign w_w7 = key_word(in_key, 2'd3);

    assign w_w3 = w_w7 ^ w_w6;
    assign w_w2 = w_w6 ^ w_w5;
    assign w_w1 = w_w5 ^ w_w4;

    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            aes_sbox u_sbox (
                .in_byte  (w_rot[8*gi +: 8]),
                .out_byte (w_sub[8*gi +: 8])
            );
        end
    endgenerate

    assign w_w0    = w_w4 ^ w_sub ^ rcon(rc);
    assign out_key = {w_w0, w_w1, w_w2, w_w3};

endmodule

`default_nettype wire

// File: rtl/aes_sbox.sv
// ============================================================================
// Module   : aes_sbox
// Brief    : AES forward S-box, single byte, combinational table lookup
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_sbox (
    input  wire logic [7:0] in_byte,
    output logic      [7:0] out_byte
);

    // Entry 0 occupies the top byte, so entry x starts at bit 8*(255-x).
    localparam logic [2047:0] C_SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_byte = C_SBOX_TABLE[{~in_byte, 3'b000} +: 8];

endmodule

`default_nettype wire

// File: rtl/aes_inv_key_schedule.sv
// ============================================================================
// Module   : aes_inv_key_schedule
// Brief    : Walks AES-128 round keys from round NR back to 0, one per handshake
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_inv_key_schedule
    import aes_inv_key_schedule_pkg::*;
#(
    parameter int NR = NR_AES128   // only AES-128 (10) is meaningful
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    aes_inv_key_schedule_if.slave  bus
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [3:0] C_NR    = 4'(NR);

    logic [0:0]   state_q, state_d;
    logic [127:0] key_q;
    logic [3:0]   round_q;
    logic [127:0] step_key;
    logic         accept;
    logic         advance;

    assign accept  = (state_q == ST_IDLE) && bus.in_valid;
    assign advance = (state_q == ST_RUN) && bus.out_ready;

    aes_inv_key_step u_step (
        .rc      (round_q),
        .in_key  (key_q),
        .out_key (step_key)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.in_valid) state_d = ST_RUN;
            ST_RUN:  if (bus.out_ready && (round_q == 4'd0)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == ST_IDLE);
        bus.out_valid = (state_q == ST_RUN);
        bus.out_key   = (state_q == ST_RUN) ? key_q : 128'd0;
        bus.out_round = (state_q == ST_RUN) ? round_q : 4'd0;
        bus.out_last  = (state_q == ST_RUN) && (round_q == 4'd0);
    end

    // On the final handshake the key is left as-is; the FSM returns to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q   <= 128'd0;
            round_q <= 4'd0;
        end else if (accept) begin
            key_q   <= bus.in_key;
            round_q <= C_NR;
        end else if (advance && (round_q != 4'd0)) begin
            key_q   <= step_key;
            round_q <= round_q - 4'd1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aes_inv_key_schedule.sv
// ============================================================================
// Module   : tb_aes_inv_key_schedule
// Brief    : Self-checking bench: forward-expansion model replayed in reverse
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_inv_key_schedule;

    typedef struct packed {
        logic [127:0] key;
        logic [3:0]   round;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   hs = 0;
    int   last_hs_cyc = 0;
    int   accept_gap = 0;
    int   mode = 0;
    bit   junk_en = 1'b0;

    logic [7:0]   sb [256];
    logic [127:0] rk_model [0:10];
    logic [127:0] pend_exp [0:10];
    exp_t         exp_q [$];

    aes_inv_key_schedule_if bus ();

    aes_inv_key_schedule #(.NR(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            if (x != 0) begin
                inv = 8'h01;
                for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Forward FIPS-197 key expansion from the cipher key.
    task automatic expand(input logic [127:0] k0);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t[31:24] ^= rc;
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk_model[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Compare process: every output cycle is checked against the expected queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) begin
                accept_gap = cyc - last_hs_cyc;
                for (int r = 10; r >= 0; r--) exp_q.push_back('{key: pend_exp[r], round: 4'(r)});
            end
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    timeout("unexpected_out_valid");
                end else begin
                    chk("out_key", bus.out_key, exp_q[0].key);
                    chk("out_round", 128'(bus.out_round), 128'(exp_q[0].round));
                    chk("out_last", 128'(bus.out_last), 128'(exp_q[0].round == 4'd0));
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        hs++;
                        if (bus.out_last) last_hs_cyc = cyc;
                    end
                end
            end
        end
    end

    // Consumer backpressure and, optionally, stray in_valid pulses during a sequence.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (junk_en) begin
                if (bus.out_valid && bus.out_round >= 4'd1) begin
                    bus.in_valid = 1'($urandom_range(0, 1));
                    bus.in_key   = {$urandom, $urandom, $urandom, $urandom};
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
    end

    task automatic send_key(input logic [127:0] k0);
        int n = 0;
        expand(k0);
        pend_exp   = rk_model;
        bus.in_key = rk_model[10];
        bus.in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 100);
        if (!bus.in_ready) timeout("key_accept");
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(exp_q.size() == 0 && bus.in_ready && !bus.out_valid) && n < 500);
        if (n >= 500) timeout("wait_idle");
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] C_FIPS_K0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    initial begin
        int n;
        int hs0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_key   = 128'd0;
        build_sbox();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_out_key", bus.out_key, 128'd0);
        chk("rst_out_round", 128'(bus.out_round), 128'd0);
        chk("rst_out_last", 128'(bus.out_last), 128'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // FIPS-197 A.1 vector, plus literal pins on the model itself.
        expand(C_FIPS_K0);
        chk("model_rk10", rk_model[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("model_rk9", rk_model[9], 128'hac7766f319fadc2128d12941575c006e);
        chk("model_rk1", rk_model[1], 128'ha0fafe1788542cb123a339392a6c7605);
        mode = 0;
        send_key(C_FIPS_K0);
        wait_idle();

        // No backpressure: 11 contiguous output cycles.
        send_key({$urandom, $urandom, $urandom, $urandom});
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (!bus.out_valid) break;
            n++;
        end
        chk("burst_len", 128'(n), 128'd11);
        chk("burst_in_ready", 128'(bus.in_ready), 128'd1);
        wait_idle();

        // Random backpressure with stray in_valid during the sequence.
        mode = 1;
        send_key(C_FIPS_K0);
        junk_en = 1'b1;
        wait_idle();
        junk_en = 1'b0;
        bus.in_valid = 1'b0;

        // Asynchronous reset in the middle of a sequence.
        mode = 0;
        send_key({$urandom, $urandom, $urandom, $urandom});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.out_valid && bus.out_round == 4'd5) && n < 100);
        if (n >= 100) timeout("reach_round5");
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("midrst_in_ready", 128'(bus.in_ready), 128'd1);
        chk("midrst_out_key", bus.out_key, 128'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        hs0 = hs;
        send_key({$urandom, $urandom, $urandom, $urandom});
        wait_idle();
        chk("post_rst_hs", 128'(hs - hs0), 128'd11);

        // Back-to-back keys with in_valid held high.
        hs0 = hs;
        expand({$urandom, $urandom, $urandom, $urandom});
        pend_exp     = rk_model;
        bus.in_key   = rk_model[10];
        bus.in_valid = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        expand({$urandom, $urandom, $urandom, $urandom});
        pend_exp   = rk_model;
        bus.in_key = rk_model[10];
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 100);
        if (n >= 100) timeout("b2b_accept");
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_idle();
        chk("b2b_gap", 128'(accept_gap), 128'd1);
        chk("b2b_hs", 128'(hs - hs0), 128'd22);

        // Bulk random keys under random backpressure.
        mode = 1;
        for (int k = 0; k < 1000; k++) begin
            send_key({$urandom, $urandom, $urandom, $urandom});
            junk_en = k[0];
            wait_idle();
            junk_en = 1'b0;
            bus.in_valid = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
